axil_mem_arbiter: RTL and testbench

AXIL_MEM_ARBITER -- requirements
Module: axil_mem_arbiter

---
 rtl/axil_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_axil_mem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axil_mem_arbiter.sv
// Two-path (read/write) arbiter onto a single simple memory port.
// Round-robin on ties, one access in flight, optional MREADY wait timeout.
module axil_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    rd_req,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic                    wr_req,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    output logic                    rd_done,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [1:0]              rd_resp,
    output logic                    wr_done,
    output logic [1:0]              wr_resp,
    output logic                    MVALID,
    output logic                    MWRITE,
    output logic [ADDR_WIDTH-1:0]   MADDR,
    output logic [DATA_WIDTH-1:0]   MWDATA,
    output logic [DATA_WIDTH/8-1:0] MWSTRB,
    input  logic                    MREADY,
    input  logic [DATA_WIDTH-1:0]   MDATA,
    input  logic [1:0]              MRESP
);

    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic       TO_EN      = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST    = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_wr_q, last_wr_d;
    logic                  mvalid_q, mvalid_d;
    logic                  mwrite_q, mwrite_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [DATA_WIDTH-1:0] mwdata_q, mwdata_d;
    logic [STRB_WIDTH-1:0] mwstrb_q, mwstrb_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  rd_done_q, rd_done_d;
    logic                  wr_done_q, wr_done_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [1:0]            rd_resp_q, rd_resp_d;
    logic [1:0]            wr_resp_q, wr_resp_d;

    logic grant_wr_s;
    logic timeout_s;

    // Grant selection: a lone request always wins, a tie goes to the path not served last.
    always_comb begin
        grant_wr_s = 1'b0;
        if (rd_req && wr_req) begin
            grant_wr_s = ~last_wr_q;
        end else begin
            grant_wr_s = wr_req;
        end
    end

    assign timeout_s = TO_EN && (cnt_q == TO_LAST);

    // Next-state and registered-output computation for the access FSM.
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        mvalid_d  = mvalid_q;
        mwrite_d  = mwrite_q;
        maddr_d   = maddr_q;
        mwdata_d  = mwdata_q;
        mwstrb_d  = mwstrb_q;
        cnt_d     = cnt_q;
        rd_done_d = 1'b0;
        wr_done_d = 1'b0;
        rd_data_d = rd_data_q;
        rd_resp_d = rd_resp_q;
        wr_resp_d = wr_resp_q;

        case (state_q)
            IDLE: begin
                if (rd_req || wr_req) begin
                    state_d   = ACCESS;
                    mvalid_d  = 1'b1;
                    mwrite_d  = grant_wr_s;
                    last_wr_d = grant_wr_s;
                    maddr_d   = grant_wr_s ? wr_addr : rd_addr;
                    mwdata_d  = grant_wr_s ? wr_data : '0;
                    mwstrb_d  = grant_wr_s ? wr_strb : '0;
                    cnt_d     = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end

            ACCESS: begin
                // MREADY is checked first so a late accept beats the timeout.
                if (MREADY) begin
                    state_d  = RESP;
                    mvalid_d = 1'b0;
                    if (mwrite_q) begin
                        wr_done_d = 1'b1;
                        wr_resp_d = MRESP;
                    end else begin
                        rd_done_d = 1'b1;
                        rd_data_d = MDATA;
                        rd_resp_d = MRESP;
                    end
                end else if (timeout_s) begin
                    state_d  = RESP;
                    mvalid_d = 1'b0;
                    if (mwrite_q) begin
                        wr_done_d = 1'b1;
                        wr_resp_d = RESP_SLVERR;
                    end else begin
                        rd_done_d = 1'b1;
                        rd_data_d = '0;
                        rd_resp_d = RESP_SLVERR;
                    end
                end else begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d  = IDLE;
                mvalid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b1;
            mvalid_q  <= 1'b0;
            mwrite_q  <= 1'b0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
            mwstrb_q  <= '0;
            cnt_q     <= 8'd0;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
            rd_data_q <= '0;
            rd_resp_q <= 2'b00;
            wr_resp_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            mvalid_q  <= mvalid_d;
            mwrite_q  <= mwrite_d;
            maddr_q   <= maddr_d;
            mwdata_q  <= mwdata_d;
            mwstrb_q  <= mwstrb_d;
            cnt_q     <= cnt_d;
            rd_done_q <= rd_done_d;
            wr_done_q <= wr_done_d;
            rd_data_q <= rd_data_d;
            rd_resp_q <= rd_resp_d;
            wr_resp_q <= wr_resp_d;
        end
    end

    assign MVALID  = mvalid_q;
    assign MWRITE  = mwrite_q;
    assign MADDR   = maddr_q;
    assign MWDATA  = mwdata_q;
    assign MWSTRB  = mwstrb_q;
    assign rd_done = rd_done_q;
    assign wr_done = wr_done_q;
    assign rd_data = rd_data_q;
    assign rd_resp = rd_resp_q;
    assign wr_resp = wr_resp_q;

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Bench for axil_mem_arbiter: vector table plus tie, timeout and reset sequences,
// with completions checked against a scoreboard queue.
module tb_axil_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          rd_req, wr_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_strb;
    logic          rd_done, wr_done;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_resp, wr_resp;
    logic          MVALID, MWRITE;
    logic [AW-1:0] MADDR;
    logic [DW-1:0] MWDATA;
    logic [3:0]    MWSTRB;
    logic          MREADY;
    logic [DW-1:0] MDATA;
    logic [1:0]    MRESP;

    axil_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_done(rd_done), .rd_data(rd_data), .rd_resp(rd_resp),
        .wr_done(wr_done), .wr_resp(wr_resp),
        .MVALID(MVALID), .MWRITE(MWRITE), .MADDR(MADDR), .MWDATA(MWDATA), .MWSTRB(MWSTRB),
        .MREADY(MREADY), .MDATA(MDATA), .MRESP(MRESP)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_wr;
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } exp_t;

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    strb;
        int            delay;   // cycles of MREADY=0 before accept; 255 = never
        logic [DW-1:0] mdata;
        logic [1:0]    mresp;
        logic [DW-1:0] exp_data;
        logic [1:0]    exp_resp;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (resetn && (rd_done || wr_done)) begin
            if (rd_done && wr_done) begin
                tests++;
                fails++;
                $display("FAIL both_done: rd_done=1 wr_done=1, expected only one");
            end
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: rd_done=%0b wr_done=%0b, expected none", rd_done, wr_done);
            end else begin
                mon_e = sb.pop_front();
                check("done_path_is_wr", {63'd0, wr_done}, {63'd0, mon_e.is_wr});
                if (mon_e.is_wr) begin
                    check("wr_resp", {62'd0, wr_resp}, {62'd0, mon_e.resp});
                end else begin
                    check("rd_data", {32'd0, rd_data}, {32'd0, mon_e.data});
                    check("rd_resp", {62'd0, rd_resp}, {62'd0, mon_e.resp});
                end
            end
        end
    end

    // Waits for MVALID, checks the presented access, answers it and returns at the done negedge.
    task automatic serve(input logic is_wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [3:0] strb, input int delay, input logic [DW-1:0] mdata,
                         input logic [1:0] mresp, input logic [DW-1:0] exp_data,
                         input logic [1:0] exp_resp, output int waited);
        exp_t e;
        bit   finished;
        waited = 0;
        while (!MVALID && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!MVALID) begin
            tests++;
            fails++;
            $display("FAIL mvalid_wait: MVALID=0 after %0d cycles, expected 1", waited);
            return;
        end
        finished = 1'b0;
        for (int k = 0; k < 20 && !finished; k++) begin
            check("access_mvalid", {63'd0, MVALID}, 64'd1);
            check("access_mwrite", {63'd0, MWRITE}, {63'd0, is_wr});
            check("access_maddr", {32'd0, MADDR}, {32'd0, addr});
            if (is_wr) begin
                check("access_mwdata", {32'd0, MWDATA}, {32'd0, wdata});
                check("access_mwstrb", {60'd0, MWSTRB}, {60'd0, strb});
            end
            e.is_wr = is_wr;
            e.data  = exp_data;
            e.resp  = exp_resp;
            if (k == delay) begin
                MREADY = 1'b1;
                MDATA  = mdata;
                MRESP  = mresp;
                sb.push_back(e);
                finished = 1'b1;
            end else begin
                MREADY = 1'b0;
                MDATA  = 32'hFFFF_0000;
                MRESP  = 2'b11;
                if (k == TO - 1) begin
                    sb.push_back(e);
                    finished = 1'b1;
                end
            end
            @(negedge clk);
        end
        MREADY = 1'b0;
        check("done_pulse", {63'd0, rd_done | wr_done}, 64'd1);
        check("mvalid_low_in_resp", {63'd0, MVALID}, 64'd0);
    endtask

    vec_t vecs[6];
    int   w;

    initial begin
        vecs[0] = '{1'b0, 32'h10, 32'h0,         4'h0, 0,   32'hA5A5A5A5, 2'b00, 32'hA5A5A5A5, 2'b00};
        vecs[1] = '{1'b1, 32'h20, 32'h12345678,  4'hF, 3,   32'h0,        2'b00, 32'h0,        2'b00};
        vecs[2] = '{1'b0, 32'h30, 32'h0,         4'h0, 255, 32'h11111111, 2'b00, 32'h0,        2'b10};
        vecs[3] = '{1'b0, 32'h44, 32'h0,         4'h0, 3,   32'hDEADBEEF, 2'b01, 32'hDEADBEEF, 2'b01};
        vecs[4] = '{1'b1, 32'h50, 32'hCAFEF00D,  4'h3, 255, 32'h0,        2'b00, 32'h0,        2'b10};
        vecs[5] = '{1'b0, 32'h60, 32'h0,         4'h0, 1,   32'h0BADF00D, 2'b11, 32'h0BADF00D, 2'b11};

        resetn = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        MREADY = 1'b0; MDATA = '0; MRESP = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_mvalid", {63'd0, MVALID}, 64'd0);
        check("rst_mwrite", {63'd0, MWRITE}, 64'd0);
        check("rst_maddr", {32'd0, MADDR}, 64'd0);
        check("rst_mwdata", {32'd0, MWDATA}, 64'd0);
        check("rst_done", {62'd0, rd_done, wr_done}, 64'd0);
        check("rst_rd_data", {32'd0, rd_data}, 64'd0);
        check("rst_resps", {60'd0, rd_resp, wr_resp}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Tie held from reset: read, write, read.
        rd_req = 1'b1; rd_addr = 32'h100;
        wr_req = 1'b1; wr_addr = 32'h200; wr_data = 32'h55AA55AA; wr_strb = 4'hF;
        serve(1'b0, 32'h100, 32'h0, 4'h0, 0, 32'h00000001, 2'b00, 32'h00000001, 2'b00, w);
        check("tie1_latency", w, 64'd1);
        serve(1'b1, 32'h200, 32'h55AA55AA, 4'hF, 0, 32'h0, 2'b01, 32'h0, 2'b01, w);
        serve(1'b0, 32'h100, 32'h0, 4'h0, 0, 32'h00000003, 2'b00, 32'h00000003, 2'b00, w);
        rd_req = 1'b0; wr_req = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("idle_mvalid", {63'd0, MVALID}, 64'd0);
            check("idle_no_done", {62'd0, rd_done, wr_done}, 64'd0);
            if (vecs[i].is_wr) begin
                wr_req = 1'b1; wr_addr = vecs[i].addr; wr_data = vecs[i].wdata; wr_strb = vecs[i].strb;
            end else begin
                rd_req = 1'b1; rd_addr = vecs[i].addr;
            end
            serve(vecs[i].is_wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].delay,
                  vecs[i].mdata, vecs[i].mresp, vecs[i].exp_data, vecs[i].exp_resp, w);
            check("vec_latency", w, 64'd1);
            rd_req = 1'b0; wr_req = 1'b0;
        end

        @(negedge clk);
        check("hold_rd_data", {32'd0, rd_data}, 64'h0BADF00D);
        check("hold_rd_resp", {62'd0, rd_resp}, 64'd3);
        check("hold_wr_resp", {62'd0, wr_resp}, 64'd2);
        check("hold_done_low", {62'd0, rd_done, wr_done}, 64'd0);

        // Reset during an access: aborted without a done pulse, then re-granted.
        rd_req = 1'b1; rd_addr = 32'h70;
        @(negedge clk);
        check("pre_rst_mvalid", {63'd0, MVALID}, 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_mvalid", {63'd0, MVALID}, 64'd0);
        check("midrst_maddr", {32'd0, MADDR}, 64'd0);
        repeat (2) @(negedge clk);
        check("midrst_no_done", {62'd0, rd_done, wr_done}, 64'd0);
        resetn = 1'b1;
        serve(1'b0, 32'h70, 32'h0, 4'h0, 0, 32'h77777777, 2'b00, 32'h77777777, 2'b00, w);
        rd_req = 1'b0;

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
